bsg_cgol_job_issuer: RTL and testbench
======================================

Name: bsg_cgol_job_issuer

Overview:
Host-side initiator for the Game-of-Life controller. Accepts game jobs (initial board plus frame count) on an upstream valid/ready channel and presents the board to the cell-array loader. Issues the frame count to the controller's valid/ready input channel, then waits for the controller's done-valid. Captures the evolved board into a one-entry result buffer and acknowledges the controller with a yumi pulse.

Parameters:
max_game_length_p, 1024, largest legal frame count; game_len_width_lp = BSG_SAFE_CLOG2(max_game_length_p+1)
board_width_p, 8, cells per row
board_height_p, 8, rows; board_bits_lp = board_width_p*board_height_p
timeout_cycles_p, 65535, WAIT-state watchdog limit (used only with the optional feature)

Ports:
clk_i  in  1  clock
reset_n_i  in  1  asynchronous active-low reset
job_frames_i  in  game_len_width_lp  requested frame count
job_board_i  in  board_bits_lp  initial board
job_v_i  in  1  job valid
job_ready_o  out  1  job accepted when job_v_i & job_ready_o
ctrl_frames_o  out  game_len_width_lp  frame count to controller
ctrl_board_o  out  board_bits_lp  latched initial board for cell-array load
ctrl_v_o  out  1  request valid to controller
ctrl_ready_i  in  1  controller ready
ctrl_v_i  in  1  controller done-valid
ctrl_board_i  in  board_bits_lp  evolved board from cell array
ctrl_yumi_o  out  1  consume controller result
res_frames_o  out  game_len_width_lp  frames actually run
res_board_o  out  board_bits_lp  result board
res_v_o  out  1  result valid
res_ready_i  in  1  result consumer ready
jobs_done_o  out  16  completed-job counter, wraps 0xFFFF->0
busy_o  out  1  state != IDLE

Behaviour:
- Reset (reset_n_i low, async): state=IDLE; res_v_o, ctrl_v_o, ctrl_yumi_o, busy_o = 0; jobs_done_o=0; job/result registers=0. Asserting reset mid-operation discards the in-flight job and any buffered result. The controller is reset separately.
- States: IDLE, ISSUE, WAIT, BYPASS, DRAIN.
- job_ready_o = (state==IDLE). On acceptance, latch the frame count and board.
  - Frame count is clamped: values > max_game_length_p become max_game_length_p.
  - Frame count 0 -> BYPASS; otherwise -> ISSUE.
- ISSUE: ctrl_v_o=1; ctrl_frames_o and ctrl_board_o are stable. On ctrl_v_o & ctrl_ready_i -> WAIT. Latency: acceptance in cycle 0 gives ctrl_v_o in cycle 1.
- WAIT: ctrl_yumi_o = ctrl_v_i & (~res_v_o | res_ready_i), combinational.
  - On yumi: load ctrl_board_i and the latched frames into the result buffer, set res_v_o next cycle, increment jobs_done_o, go to IDLE.
- BYPASS: when the buffer is free or draining (~res_v_o | res_ready_i):
  - load the latched board and frames=0, set res_v_o, increment jobs_done_o, go to IDLE.
  - The controller is not touched.
- Result buffer: res_v_o holds until res_ready_i.
  - Simultaneous drain and load in one cycle keeps res_v_o=1 with the new data.
  - Output data is stable while res_v_o & ~res_ready_i.
- DRAIN: entered only via the optional feature. ctrl_yumi_o = ctrl_v_i. On the yumi, discard the board -> IDLE.
- ctrl_yumi_o is never asserted outside WAIT/DRAIN. ctrl_v_o is never asserted outside ISSUE.

Optional Feature:
BSG_CGOL_ISSUER_TIMEOUT_EN
- With the macro:
  - A watchdog counter clears on entry to WAIT and increments each WAIT cycle.
  - On reaching timeout_cycles_p with no yumi, and the buffer free, load a result with the original board, frames=0 and res_timeout_o=1. Increment jobs_done_o and go to DRAIN.
  - Adds output res_timeout_o (1 bit), registered with the result buffer.
- Without the macro: no counter, no res_timeout_o port, no DRAIN state. WAIT waits indefinitely.

Test Plan:
- Reset: hold reset_n_i low mid-ISSUE, release -> state IDLE, job_ready_o=1, res_v_o=0, jobs_done_o=0, ctrl_v_o=0.
- Normal job: frames=5, board=0x0000001C00000000, ctrl_ready_i=1 -> ctrl_v_o the next cycle; ctrl_v_i after 7 cycles with board X -> ctrl_yumi_o the same cycle; next cycle res_v_o=1, res_board_o=X, res_frames_o=5, jobs_done_o=1.
- Backpressure: res_ready_i=0 with a result held, second job completes -> ctrl_yumi_o stays 0 while ctrl_v_i=1; raise res_ready_i -> first result drains and yumi fires the same cycle; second result follows the next cycle.
- Zero frames: frames=0, board=B -> no ctrl_v_o; res_v_o the next cycle with res_board_o=B, res_frames_o=0.
- Clamp: max_game_length_p=10, frames=15 -> ctrl_frames_o=10, res_frames_o=10.
- Timeout (macro on, timeout_cycles_p=20): ctrl_v_i held 0 -> at cycle 20 of WAIT, res_v_o=1 and res_timeout_o=1 with the original board; later ctrl_v_i=1 -> yumi in DRAIN, no new result, return to IDLE.

Source files
------------

// File: rtl/bsg_cgol_job_issuer.sv
// Host-side job issuer for the Game-of-Life controller: accepts a job, issues it, buffers one result.
// Optional macro BSG_CGOL_ISSUER_TIMEOUT_EN adds a WAIT watchdog, a DRAIN state and res_timeout_o.
module bsg_cgol_job_issuer #(
  parameter int max_game_length_p = 1024,
  parameter int board_width_p     = 8,
  parameter int board_height_p    = 8,
  parameter int timeout_cycles_p  = 65535,
  localparam int game_len_width_lp = (max_game_length_p < 1) ? 1 : $clog2(max_game_length_p + 1),
  localparam int board_bits_lp     = board_width_p * board_height_p
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic [game_len_width_lp-1:0] job_frames_i,
  input  logic [board_bits_lp-1:0]     job_board_i,
  input  logic                         job_v_i,
  output logic                         job_ready_o,
  output logic [game_len_width_lp-1:0] ctrl_frames_o,
  output logic [board_bits_lp-1:0]     ctrl_board_o,
  output logic                         ctrl_v_o,
  input  logic                         ctrl_ready_i,
  input  logic                         ctrl_v_i,
  input  logic [board_bits_lp-1:0]     ctrl_board_i,
  output logic                         ctrl_yumi_o,
  output logic [game_len_width_lp-1:0] res_frames_o,
  output logic [board_bits_lp-1:0]     res_board_o,
  output logic                         res_v_o,
  input  logic                         res_ready_i,
`ifdef BSG_CGOL_ISSUER_TIMEOUT_EN
  output logic                         res_timeout_o,
`endif
  output logic [15:0]                  jobs_done_o,
  output logic                         busy_o
);

  if (max_game_length_p < 1 || timeout_cycles_p < 1) begin : g_param_check
    $error("bsg_cgol_job_issuer: max_game_length_p and timeout_cycles_p must be >= 1");
  end

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    BYPASS
`ifdef BSG_CGOL_ISSUER_TIMEOUT_EN
    , DRAIN
`endif
  } state_e;

  localparam logic [game_len_width_lp-1:0] max_frames_lp = game_len_width_lp'(max_game_length_p);

  state_e                       state_q, state_d;
  logic [game_len_width_lp-1:0] frames_q, frames_d;
  logic [board_bits_lp-1:0]     board_q, board_d;
  logic                         res_v_q, res_v_d;
  logic [game_len_width_lp-1:0] res_frames_q, res_frames_d;
  logic [board_bits_lp-1:0]     res_board_q, res_board_d;
  logic [15:0]                  jobs_done_q, jobs_done_d;
  logic                         yumi;
  logic                         buf_free;

`ifdef BSG_CGOL_ISSUER_TIMEOUT_EN
  localparam int wd_width_lp = (timeout_cycles_p < 1) ? 1 : $clog2(timeout_cycles_p + 1);
  localparam logic [wd_width_lp-1:0] wd_last_lp = wd_width_lp'(timeout_cycles_p - 1);
  logic [wd_width_lp-1:0] wd_cnt_q, wd_cnt_d;
  logic                   res_timeout_q, res_timeout_d;
`endif

  function automatic logic [game_len_width_lp-1:0] clamp_frames(input logic [game_len_width_lp-1:0] f);
    return (f > max_frames_lp) ? max_frames_lp : f;
  endfunction

  // The result buffer can take new data when empty or being drained this very cycle.
  assign buf_free = ~res_v_q | res_ready_i;

  always_comb begin
    state_d      = state_q;
    frames_d     = frames_q;
    board_d      = board_q;
    res_v_d      = res_v_q & ~res_ready_i;
    res_frames_d = res_frames_q;
    res_board_d  = res_board_q;
    jobs_done_d  = jobs_done_q;
    yumi         = 1'b0;
`ifdef BSG_CGOL_ISSUER_TIMEOUT_EN
    wd_cnt_d      = wd_cnt_q;
    res_timeout_d = res_timeout_q;
`endif
    case (state_q)
      IDLE: begin
        if (job_v_i) begin
          frames_d = clamp_frames(job_frames_i);
          board_d  = job_board_i;
          state_d  = (frames_d == '0) ? BYPASS : ISSUE;
        end
      end
      ISSUE: begin
        if (ctrl_ready_i) begin
          state_d = WAIT;
`ifdef BSG_CGOL_ISSUER_TIMEOUT_EN
          wd_cnt_d = '0;
`endif
        end
      end
      WAIT: begin
        yumi = ctrl_v_i & buf_free;
        if (yumi) begin
          res_v_d      = 1'b1;
          res_board_d  = ctrl_board_i;
          res_frames_d = frames_q;
          jobs_done_d  = jobs_done_q + 16'd1;
          state_d      = IDLE;
`ifdef BSG_CGOL_ISSUER_TIMEOUT_EN
          res_timeout_d = 1'b0;
        end else if (wd_cnt_q == wd_last_lp && buf_free) begin
          // Give up on the controller; its late answer is swallowed in DRAIN.
          res_v_d       = 1'b1;
          res_board_d   = board_q;
          res_frames_d  = '0;
          res_timeout_d = 1'b1;
          jobs_done_d   = jobs_done_q + 16'd1;
          state_d       = DRAIN;
        end else if (wd_cnt_q != wd_last_lp) begin
          wd_cnt_d = wd_cnt_q + 1'b1;
`endif
        end
      end
      BYPASS: begin
        if (buf_free) begin
          res_v_d      = 1'b1;
          res_board_d  = board_q;
          res_frames_d = '0;
          jobs_done_d  = jobs_done_q + 16'd1;
          state_d      = IDLE;
`ifdef BSG_CGOL_ISSUER_TIMEOUT_EN
          res_timeout_d = 1'b0;
`endif
        end
      end
`ifdef BSG_CGOL_ISSUER_TIMEOUT_EN
      DRAIN: begin
        yumi = ctrl_v_i;
        if (yumi) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= IDLE;
      frames_q     <= '0;
      board_q      <= '0;
      res_v_q      <= 1'b0;
      res_frames_q <= '0;
      res_board_q  <= '0;
      jobs_done_q  <= '0;
`ifdef BSG_CGOL_ISSUER_TIMEOUT_EN
      wd_cnt_q      <= '0;
      res_timeout_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      frames_q     <= frames_d;
      board_q      <= board_d;
      res_v_q      <= res_v_d;
      res_frames_q <= res_frames_d;
      res_board_q  <= res_board_d;
      jobs_done_q  <= jobs_done_d;
`ifdef BSG_CGOL_ISSUER_TIMEOUT_EN
      wd_cnt_q      <= wd_cnt_d;
      res_timeout_q <= res_timeout_d;
`endif
    end
  end

  assign job_ready_o   = (state_q == IDLE);
  assign busy_o        = (state_q != IDLE);
  assign ctrl_v_o      = (state_q == ISSUE);
  assign ctrl_frames_o = frames_q;
  assign ctrl_board_o  = board_q;
  assign ctrl_yumi_o   = yumi;
  assign res_v_o       = res_v_q;
  assign res_frames_o  = res_frames_q;
  assign res_board_o   = res_board_q;
  assign jobs_done_o   = jobs_done_q;
`ifdef BSG_CGOL_ISSUER_TIMEOUT_EN
  assign res_timeout_o = res_timeout_q;
`endif

endmodule

// File: tb/tb_bsg_cgol_job_issuer.sv
// Self-checking bench for bsg_cgol_job_issuer: directed scenarios plus a randomized run
// against a queue-based reference model of the job/result flow.
module tb_bsg_cgol_job_issuer;
  localparam int MAXF = 10;
  localparam int TOC  = 20;
  localparam int W    = $clog2(MAXF + 1);
  localparam int BB   = 64;

  logic          clk_i = 1'b0;
  logic          reset_n_i = 1'b1;
  logic [W-1:0]  job_frames_i = '0;
  logic [BB-1:0] job_board_i = '0;
  logic          job_v_i = 1'b0;
  logic          job_ready_o;
  logic [W-1:0]  ctrl_frames_o;
  logic [BB-1:0] ctrl_board_o;
  logic          ctrl_v_o;
  logic          ctrl_ready_i = 1'b0;
  logic          ctrl_v_i = 1'b0;
  logic [BB-1:0] ctrl_board_i = '0;
  logic          ctrl_yumi_o;
  logic [W-1:0]  res_frames_o;
  logic [BB-1:0] res_board_o;
  logic          res_v_o;
  logic          res_ready_i = 1'b0;
  logic [15:0]   jobs_done_o;
  logic          busy_o;
`ifdef BSG_CGOL_ISSUER_TIMEOUT_EN
  logic          res_timeout_o;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int exp_done = 0;

  always #5 clk_i = ~clk_i;

  bsg_cgol_job_issuer #(
    .max_game_length_p(MAXF), .board_width_p(8), .board_height_p(8), .timeout_cycles_p(TOC)
  ) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .job_frames_i(job_frames_i), .job_board_i(job_board_i), .job_v_i(job_v_i), .job_ready_o(job_ready_o),
    .ctrl_frames_o(ctrl_frames_o), .ctrl_board_o(ctrl_board_o), .ctrl_v_o(ctrl_v_o),
    .ctrl_ready_i(ctrl_ready_i), .ctrl_v_i(ctrl_v_i), .ctrl_board_i(ctrl_board_i), .ctrl_yumi_o(ctrl_yumi_o),
    .res_frames_o(res_frames_o), .res_board_o(res_board_o), .res_v_o(res_v_o), .res_ready_i(res_ready_i),
`ifdef BSG_CGOL_ISSUER_TIMEOUT_EN
    .res_timeout_o(res_timeout_o),
`endif
    .jobs_done_o(jobs_done_o), .busy_o(busy_o)
  );

  function automatic logic [BB-1:0] rand_board();
    return {$urandom, $urandom};
  endfunction

  // Presents a job until it is accepted; returns at the negedge right after the accepting edge.
  task automatic accept_job(input logic [W-1:0] f, input logic [BB-1:0] b);
    int k = 0;
    @(negedge clk_i);
    job_v_i = 1'b1; job_frames_i = f; job_board_i = b;
    #1;
    while (!job_ready_o && k < 50) begin @(negedge clk_i); #1; k++; end
    n_tests++;
    if (job_ready_o !== 1'b1) begin n_fail++; $display("FAIL accept_wait job_ready_o=%b required 1", job_ready_o); end
    @(negedge clk_i);
    job_v_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [BB-1:0] b0;
    ctrl_ready_i = 1'b0; ctrl_v_i = 1'b0; res_ready_i = 1'b0; job_v_i = 1'b0;
    @(negedge clk_i); reset_n_i = 1'b0;
    @(negedge clk_i); #1;
    n_tests++; if (job_ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_job_ready got %b required 1", job_ready_o); end
    n_tests++; if (res_v_o !== 1'b0) begin n_fail++; $display("FAIL rst_res_v got %b required 0", res_v_o); end
    n_tests++; if (ctrl_v_o !== 1'b0) begin n_fail++; $display("FAIL rst_ctrl_v got %b required 0", ctrl_v_o); end
    n_tests++; if (jobs_done_o !== 16'd0) begin n_fail++; $display("FAIL rst_jobs_done got %0d required 0", jobs_done_o); end
    @(negedge clk_i); reset_n_i = 1'b1;
    // Hold a bypass result, then park a job in ISSUE and reset underneath it.
    b0 = rand_board();
    accept_job(W'(0), b0);
    accept_job(W'(3), rand_board());
    #1;
    n_tests++; if (ctrl_v_o !== 1'b1) begin n_fail++; $display("FAIL rst_pre_ctrl_v got %b required 1", ctrl_v_o); end
    n_tests++; if (res_v_o !== 1'b1 || res_board_o !== b0) begin n_fail++; $display("FAIL rst_pre_res got v=%b b=%h required v=1 b=%h", res_v_o, res_board_o, b0); end
    reset_n_i = 1'b0;
    #1;
    n_tests++; if (ctrl_v_o !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ctrl_v got %b required 0", ctrl_v_o); end
    n_tests++; if (res_v_o !== 1'b0) begin n_fail++; $display("FAIL rst_mid_res_v got %b required 0", res_v_o); end
    n_tests++; if (jobs_done_o !== 16'd0) begin n_fail++; $display("FAIL rst_mid_jobs_done got %0d required 0", jobs_done_o); end
    n_tests++; if (busy_o !== 1'b0 || job_ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_mid_state busy=%b ready=%b required 0/1", busy_o, job_ready_o); end
    n_tests++; if (res_board_o !== '0 || res_frames_o !== '0) begin n_fail++; $display("FAIL rst_mid_res_data got %h/%0d required 0/0", res_board_o, res_frames_o); end
`ifdef BSG_CGOL_ISSUER_TIMEOUT_EN
    n_tests++; if (res_timeout_o !== 1'b0) begin n_fail++; $display("FAIL rst_timeout got %b required 0", res_timeout_o); end
`endif
    @(negedge clk_i); reset_n_i = 1'b1;
    exp_done = 0;
    #1;
    n_tests++; if (job_ready_o !== 1'b1 || ctrl_v_o !== 1'b0) begin n_fail++; $display("FAIL rst_after ready=%b ctrl_v=%b required 1/0", job_ready_o, ctrl_v_o); end
  endtask

  task automatic test_normal();
    logic [BB-1:0] b, x;
    b = 64'h0000001C00000000; x = rand_board();
    res_ready_i = 1'b0; ctrl_ready_i = 1'b1;
    accept_job(W'(5), b);
    #1;
    n_tests++; if (ctrl_v_o !== 1'b1) begin n_fail++; $display("FAIL norm_ctrl_v got %b required 1", ctrl_v_o); end
    n_tests++; if (ctrl_frames_o !== W'(5) || ctrl_board_o !== b) begin n_fail++; $display("FAIL norm_ctrl_data got %0d/%h required 5/%h", ctrl_frames_o, ctrl_board_o, b); end
    n_tests++; if (job_ready_o !== 1'b0 || busy_o !== 1'b1) begin n_fail++; $display("FAIL norm_busy ready=%b busy=%b required 0/1", job_ready_o, busy_o); end
    repeat (7) begin
      @(negedge clk_i); #1;
      n_tests++; if (ctrl_v_o !== 1'b0 || ctrl_yumi_o !== 1'b0 || res_v_o !== 1'b0) begin n_fail++; $display("FAIL norm_wait ctrl_v=%b yumi=%b res_v=%b required 0/0/0", ctrl_v_o, ctrl_yumi_o, res_v_o); end
    end
    @(negedge clk_i); ctrl_v_i = 1'b1; ctrl_board_i = x; #1;
    n_tests++; if (ctrl_yumi_o !== 1'b1) begin n_fail++; $display("FAIL norm_yumi got %b required 1", ctrl_yumi_o); end
    @(negedge clk_i); ctrl_v_i = 1'b0; ctrl_board_i = rand_board(); exp_done++; #1;
    n_tests++; if (res_v_o !== 1'b1 || res_board_o !== x || res_frames_o !== W'(5)) begin n_fail++; $display("FAIL norm_result got v=%b %h/%0d required 1 %h/5", res_v_o, res_board_o, res_frames_o, x); end
    n_tests++; if (jobs_done_o !== 16'(exp_done)) begin n_fail++; $display("FAIL norm_jobs_done got %0d required %0d", jobs_done_o, exp_done); end
    n_tests++; if (job_ready_o !== 1'b1) begin n_fail++; $display("FAIL norm_idle got %b required 1", job_ready_o); end
    res_ready_i = 1'b1;
    @(negedge clk_i); res_ready_i = 1'b0; #1;
    n_tests++; if (res_v_o !== 1'b0) begin n_fail++; $display("FAIL norm_drain got %b required 0", res_v_o); end
  endtask

  task automatic test_backpressure();
    logic [BB-1:0] ra, rb;
    ra = rand_board(); rb = rand_board();
    ctrl_ready_i = 1'b1; res_ready_i = 1'b0;
    accept_job(W'(2), rand_board());
    @(negedge clk_i); ctrl_v_i = 1'b1; ctrl_board_i = ra; #1;
    n_tests++; if (ctrl_yumi_o !== 1'b1) begin n_fail++; $display("FAIL bp_first_yumi got %b required 1", ctrl_yumi_o); end
    @(negedge clk_i); ctrl_v_i = 1'b0; exp_done++;
    accept_job(W'(3), rand_board());
    @(negedge clk_i); ctrl_v_i = 1'b1; ctrl_board_i = rb;
    repeat (3) begin
      #1;
      n_tests++; if (ctrl_yumi_o !== 1'b0) begin n_fail++; $display("FAIL bp_yumi_blocked got %b required 0", ctrl_yumi_o); end
      n_tests++; if (res_v_o !== 1'b1 || res_board_o !== ra || res_frames_o !== W'(2)) begin n_fail++; $display("FAIL bp_hold got v=%b %h/%0d required 1 %h/2", res_v_o, res_board_o, res_frames_o, ra); end
      @(negedge clk_i);
    end
    res_ready_i = 1'b1; #1;
    n_tests++; if (ctrl_yumi_o !== 1'b1) begin n_fail++; $display("FAIL bp_yumi_on_drain got %b required 1", ctrl_yumi_o); end
    @(negedge clk_i); ctrl_v_i = 1'b0; res_ready_i = 1'b0; exp_done++; #1;
    n_tests++; if (res_v_o !== 1'b1 || res_board_o !== rb || res_frames_o !== W'(3)) begin n_fail++; $display("FAIL bp_second got v=%b %h/%0d required 1 %h/3", res_v_o, res_board_o, res_frames_o, rb); end
    n_tests++; if (jobs_done_o !== 16'(exp_done)) begin n_fail++; $display("FAIL bp_jobs_done got %0d required %0d", jobs_done_o, exp_done); end
    res_ready_i = 1'b1;
    @(negedge clk_i); res_ready_i = 1'b0;
  endtask

  task automatic test_zero_frames();
    logic [BB-1:0] b;
    int k = 0;
    b = rand_board();
    res_ready_i = 1'b1; ctrl_ready_i = 1'b1;
    accept_job(W'(0), b);
    #1;
    while (!res_v_o && k < 3) begin
      n_tests++; if (ctrl_v_o !== 1'b0) begin n_fail++; $display("FAIL zero_ctrl_v got %b required 0", ctrl_v_o); end
      @(negedge clk_i); #1; k++;
    end
    exp_done++;
    n_tests++; if (res_v_o !== 1'b1 || res_board_o !== b || res_frames_o !== W'(0)) begin n_fail++; $display("FAIL zero_result got v=%b %h/%0d required 1 %h/0", res_v_o, res_board_o, res_frames_o, b); end
    n_tests++; if (ctrl_v_o !== 1'b0 || jobs_done_o !== 16'(exp_done)) begin n_fail++; $display("FAIL zero_side got ctrl_v=%b done=%0d required 0/%0d", ctrl_v_o, jobs_done_o, exp_done); end
    @(negedge clk_i); res_ready_i = 1'b0;
  endtask

  task automatic test_clamp();
    int fl[4] = '{9, 10, 11, 15};
    for (int i = 0; i < 4; i++) begin
      int want;
      logic [BB-1:0] x;
      want = (fl[i] > MAXF) ? MAXF : fl[i];
      x = rand_board();
      ctrl_ready_i = 1'b1; res_ready_i = 1'b0;
      accept_job(W'(fl[i]), rand_board());
      #1;
      n_tests++; if (ctrl_frames_o !== W'(want)) begin n_fail++; $display("FAIL clamp_ctrl_frames in=%0d got %0d required %0d", fl[i], ctrl_frames_o, want); end
      @(negedge clk_i); ctrl_v_i = 1'b1; ctrl_board_i = x;
      @(negedge clk_i); ctrl_v_i = 1'b0; exp_done++; #1;
      n_tests++; if (res_v_o !== 1'b1 || res_frames_o !== W'(want) || res_board_o !== x) begin n_fail++; $display("FAIL clamp_res in=%0d got v=%b %0d required 1 %0d", fl[i], res_v_o, res_frames_o, want); end
      res_ready_i = 1'b1;
      @(negedge clk_i); res_ready_i = 1'b0;
    end
  endtask

  task automatic test_random();
    logic [BB-1:0] exp_b[$];
    int            exp_f[$];
    int            cur_f = 0, cd = 0, popped = 0, base;
    logic [BB-1:0] cur_b = '0, ctrl_res = '0, prev_b = '0, pb;
    logic [W-1:0]  prev_f = '0;
    bit            issue_pend = 0, ctrl_busy = 0, prev_hold = 0;
    base = exp_done;
    for (int cyc = 0; cyc < 3120; cyc++) begin
      bit quiet;
      quiet = (cyc >= 3000);
      @(negedge clk_i);
      job_v_i      = quiet ? 1'b0 : ($urandom_range(0, 2) == 0);
      job_frames_i = W'($urandom);
      job_board_i  = rand_board();
      ctrl_ready_i = quiet ? 1'b1 : 1'($urandom_range(0, 1));
      res_ready_i  = quiet ? 1'b1 : ($urandom_range(0, 3) != 0);
      if (ctrl_busy && cd == 0) begin ctrl_v_i = 1'b1; ctrl_board_i = ctrl_res; end
      else begin ctrl_v_i = 1'b0; ctrl_board_i = rand_board(); end
      if (ctrl_busy && cd > 0) cd--;
      #1;
      n_tests++; if (ctrl_v_o !== 1'(issue_pend)) begin n_fail++; $display("FAIL rnd_ctrl_v cyc=%0d got %b required %b", cyc, ctrl_v_o, issue_pend); end
      if (issue_pend) begin
        n_tests++; if (ctrl_frames_o !== W'(cur_f) || ctrl_board_o !== cur_b) begin n_fail++; $display("FAIL rnd_ctrl_data cyc=%0d got %0d/%h required %0d/%h", cyc, ctrl_frames_o, ctrl_board_o, cur_f, cur_b); end
      end
      n_tests++; if (ctrl_yumi_o !== (ctrl_v_i & (~res_v_o | res_ready_i))) begin n_fail++; $display("FAIL rnd_yumi cyc=%0d got %b required %b", cyc, ctrl_yumi_o, ctrl_v_i & (~res_v_o | res_ready_i)); end
      n_tests++; if (jobs_done_o !== 16'(base + popped + int'(res_v_o))) begin n_fail++; $display("FAIL rnd_jobs_done cyc=%0d got %0d required %0d", cyc, jobs_done_o, base + popped + int'(res_v_o)); end
      if (prev_hold) begin
        n_tests++; if (res_v_o !== 1'b1 || res_board_o !== prev_b || res_frames_o !== prev_f) begin n_fail++; $display("FAIL rnd_res_stable cyc=%0d got v=%b %h/%0d required 1 %h/%0d", cyc, res_v_o, res_board_o, res_frames_o, prev_b, prev_f); end
      end
      if (issue_pend || ctrl_busy) begin
        n_tests++; if (job_ready_o !== 1'b0) begin n_fail++; $display("FAIL rnd_ready_busy cyc=%0d got %b required 0", cyc, job_ready_o); end
      end
      if (res_v_o && res_ready_i) begin
        n_tests++;
        if (exp_b.size() == 0) begin n_fail++; $display("FAIL rnd_unexpected_result cyc=%0d got %h required none", cyc, res_board_o); end
        else begin
          pb = exp_b.pop_front();
          if (res_board_o !== pb || res_frames_o !== W'(exp_f[0])) begin n_fail++; $display("FAIL rnd_result cyc=%0d got %h/%0d required %h/%0d", cyc, res_board_o, res_frames_o, pb, exp_f[0]); end
          void'(exp_f.pop_front());
        end
        popped++;
      end
      if (ctrl_v_i && ctrl_yumi_o) begin exp_b.push_back(ctrl_res); exp_f.push_back(cur_f); ctrl_busy = 0; end
      if (ctrl_v_o && ctrl_ready_i) begin issue_pend = 0; ctrl_busy = 1; cd = $urandom_range(0, 4); ctrl_res = rand_board(); end
      if (job_v_i && job_ready_o) begin
        cur_f = (int'(job_frames_i) > MAXF) ? MAXF : int'(job_frames_i);
        cur_b = job_board_i;
        if (cur_f == 0) begin exp_b.push_back(cur_b); exp_f.push_back(0); end
        else issue_pend = 1;
      end
      prev_hold = res_v_o & ~res_ready_i; prev_b = res_board_o; prev_f = res_frames_o;
    end
    n_tests++; if (exp_b.size() != 0 || issue_pend || ctrl_busy) begin n_fail++; $display("FAIL rnd_leftover got %0d pending results required 0", exp_b.size()); end
    exp_done = base + popped;
    res_ready_i = 1'b0; ctrl_v_i = 1'b0;
  endtask

`ifdef BSG_CGOL_ISSUER_TIMEOUT_EN
  task automatic test_timeout();
    logic [BB-1:0] b;
    int k = 0;
    b = rand_board();
    ctrl_ready_i = 1'b1; res_ready_i = 1'b0; ctrl_v_i = 1'b0;
    accept_job(W'(4), b);
    while (!res_v_o && k < 40) begin @(negedge clk_i); #1; k++; end
    exp_done++;
    n_tests++; if (k < TOC || k > TOC + 1) begin n_fail++; $display("FAIL to_latency got %0d cycles required %0d", k, TOC); end
    n_tests++; if (res_v_o !== 1'b1 || res_timeout_o !== 1'b1 || res_board_o !== b || res_frames_o !== W'(0)) begin n_fail++; $display("FAIL to_result got v=%b t=%b %h/%0d required 1 1 %h/0", res_v_o, res_timeout_o, res_board_o, res_frames_o, b); end
    @(negedge clk_i); ctrl_v_i = 1'b1; ctrl_board_i = rand_board(); #1;
    n_tests++; if (ctrl_yumi_o !== 1'b1) begin n_fail++; $display("FAIL to_drain_yumi got %b required 1", ctrl_yumi_o); end
    @(negedge clk_i); ctrl_v_i = 1'b0; #1;
    n_tests++; if (res_board_o !== b || jobs_done_o !== 16'(exp_done) || job_ready_o !== 1'b1) begin n_fail++; $display("FAIL to_after got %h done=%0d ready=%b required %h %0d 1", res_board_o, jobs_done_o, job_ready_o, b, exp_done); end
    res_ready_i = 1'b1;
    @(negedge clk_i); res_ready_i = 1'b0;
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL global_time_limit reached, required finish earlier");
    $fatal(1, "bench time limit");
  end

  initial begin
    test_reset();
    test_normal();
    test_backpressure();
    test_zero_frames();
    test_clamp();
    test_random();
`ifdef BSG_CGOL_ISSUER_TIMEOUT_EN
    test_timeout();
`endif
    test_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
